// File: rtl/matrix_skew_feeder.sv
// rtl/matrix_skew_feeder.sv - buffers one NxN matrix and replays it diagonally skewed
// Loads N*N row-major words, then emits 2N-1 steps where lane i lags by i steps.
module matrix_skew_feeder #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 feed_en,
  output logic [N*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  output logic                 done
);

  localparam int KW = $clog2(N*N);
  localparam int TW = $clog2(2*N-1);
  localparam logic [KW-1:0] K_LAST = KW'(N*N-1);
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);

  typedef enum logic {S_LOAD, S_FEED} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [TW-1:0]        t_q, t_d;
  logic [N*WIDTH-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     mem_q [N*N];

  assign in_ready  = (state_q == S_LOAD);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

  // Storage is flat row-major, so the load index addresses it directly.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_LOAD && in_valid) begin
      mem_q[k_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      k_q         <= '0;
      t_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    t_d         = t_q;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (k_q == K_LAST) begin
            state_d = S_FEED;
            k_d     = '0;
            t_d     = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_FEED: begin
        if (feed_en) begin
          // Lane i shows column t-i of row i while that column exists, else zero pad.
          for (int i = 0; i < N; i++) begin
            if (int'(t_q) >= i && int'(t_q) - i < N) begin
              out_data_d[i*WIDTH +: WIDTH] = mem_q[KW'(i*N + int'(t_q) - i)];
            end
          end
          out_valid_d = 1'b1;
          if (t_q == T_LAST) begin
            done_d  = 1'b1;
            state_d = S_LOAD;
            k_d     = '0;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

endmodule
